// File: rtl/intc_pkg.sv
// Shared types for the interrupt controller: FSM states and d_bus push selection.
package intc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE
   } intc_state_t;

   // Encoded so that a larger value wins when several push strobes collide.
   typedef enum logic [1:0] {
      PUSH_NONE     = 2'd0,
      PUSH_INTS     = 2'd1,
      PUSH_INT_ADDR = 2'd2,
      PUSH_RETADDR  = 2'd3
   } push_sel_t;

   localparam push_sel_t PUSH_PRIO_HIGH = PUSH_RETADDR;
   localparam push_sel_t PUSH_PRIO_MID  = PUSH_INT_ADDR;
   localparam push_sel_t PUSH_PRIO_LOW  = PUSH_INTS;

   function automatic push_sel_t push_select(input logic retaddr,
                                             input logic int_addr,
                                             input logic ints);
      if (retaddr)       return PUSH_PRIO_HIGH;
      else if (int_addr) return PUSH_PRIO_MID;
      else if (ints)     return PUSH_PRIO_LOW;
      else               return PUSH_NONE;
   endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set request bit wins.
module intc_prio_enc #(
   parameter  int N     = 8,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic             valid,
   output logic [IDX_W-1:0] index
);

   always_comb begin
      valid = |req;
      index = '0;
      // Scan downwards so the last hit, the lowest index, is the one kept.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) index = IDX_W'(i);
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched, maskable, fixed-priority interrupt controller that hands the CPU a
// vector address and keeps the interrupted return address across the service.
module interrupt_controller
   import intc_pkg::*;
#(
   parameter int                DATA_W          = 16,
   parameter int                NUM_IRQ         = 8,
   parameter logic [DATA_W-1:0] VEC_BASE        = DATA_W'(16'h0010),
   parameter int                VEC_STRIDE_LOG2 = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               unmask_int,
   input  logic               mask_int,
   input  logic               write_mask,
   input  logic               store_retaddr,
   input  logic               push_retaddr,
   input  logic               push_int_addr,
   input  logic               push_ints,
   output logic               interrupt,
   inout  wire  [DATA_W-1:0]  d_bus
);

   localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   intc_state_t        state_q, state_d;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask_q;
   logic               gen_q;
   logic [DATA_W-1:0]  retaddr_q;
   logic [IDX_W-1:0]   active_id_q;

   logic [NUM_IRQ-1:0] candidates;
   logic               cand_valid;
   logic [IDX_W-1:0]   winner;
   logic               accept;
   push_sel_t          push_sel;
   logic [DATA_W-1:0]  bus_out;
   logic [DATA_W-1:0]  vec_addr;

   assign candidates = pending_q & mask_q & {NUM_IRQ{gen_q}};

   intc_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
      .req   (candidates),
      .valid (cand_valid),
      .index (winner)
   );

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE:    if (cand_valid) state_d = REQ;
         REQ: begin
            if (!cand_valid) begin
               state_d = IDLE;
            end else if (store_retaddr) begin
               state_d = SERVICE;
               accept  = 1'b1;
            end
         end
         SERVICE: if (push_retaddr) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Clear first, then OR in new edges, so a fresh edge on the accepted channel survives.
   always_comb begin
      pending_d = pending_q;
      if (accept) pending_d[winner] = 1'b0;
      pending_d = pending_d | (irq_in & ~irq_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         irq_q       <= '0;
         pending_q   <= '0;
         mask_q      <= '0;
         gen_q       <= 1'b0;
         retaddr_q   <= '0;
         active_id_q <= '0;
      end else begin
         state_q   <= state_d;
         irq_q     <= irq_in;
         pending_q <= pending_d;
         if (write_mask)      mask_q    <= d_bus[NUM_IRQ-1:0];
         if (mask_int)        gen_q     <= 1'b0;
         else if (unmask_int) gen_q     <= 1'b1;
         if (store_retaddr)   retaddr_q <= d_bus;
         if (accept)          active_id_q <= winner;
      end
   end

   assign interrupt = (state_q == REQ);
   assign vec_addr  = VEC_BASE + (DATA_W'(active_id_q) << VEC_STRIDE_LOG2);
   assign push_sel  = push_select(push_retaddr, push_int_addr, push_ints);

   always_comb begin
      bus_out = '0;
      unique case (push_sel)
         PUSH_RETADDR:  bus_out = retaddr_q;
         PUSH_INT_ADDR: bus_out = vec_addr;
         PUSH_INTS:     bus_out = DATA_W'(pending_q);
         default:       bus_out = '0;
      endcase
   end

   assign d_bus = (push_sel != PUSH_NONE) ? bus_out : 'z;

   a_single_push: assert property (@(posedge clk) disable iff (rst)
      $onehot0({push_retaddr, push_int_addr, push_ints}));

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expectations are queued as stimulus is
// applied and popped when the matching output is sampled.
module tb_interrupt_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq_in;
   logic        unmask_int, mask_int, write_mask, store_retaddr;
   logic        push_retaddr, push_int_addr, push_ints;
   logic        interrupt;
   wire  [15:0] d_bus;
   logic [15:0] tb_drv;
   logic        tb_drv_en;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } exp_t;
   exp_t sb_q[$];

   localparam logic [15:0] FLOAT_PAT = 16'hA5C3;

   assign d_bus = tb_drv_en ? tb_drv : 'z;

   always #5 clk = ~clk;

   interrupt_controller dut (
      .clk           (clk),
      .rst           (rst),
      .irq_in        (irq_in),
      .unmask_int    (unmask_int),
      .mask_int      (mask_int),
      .write_mask    (write_mask),
      .store_retaddr (store_retaddr),
      .push_retaddr  (push_retaddr),
      .push_int_addr (push_int_addr),
      .push_ints     (push_ints),
      .interrupt     (interrupt),
      .d_bus         (d_bus)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end else begin
         $display("[TB] %s ok (%h)", tag, obs);
      end
   endtask

   task automatic expect_val(input string tag, input logic [15:0] exp);
      sb_q.push_back('{tag, exp});
   endtask

   task automatic observe(input logic [15:0] obs);
      exp_t e;
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_int(input string tag, input logic exp);
      expect_val(tag, {15'b0, exp});
      observe({15'b0, interrupt});
   endtask

   // kind: 0 = push_ints, 1 = push_int_addr, 2 = push_retaddr (released before the edge)
   task automatic read_bus(input int kind, input string tag, input logic [15:0] exp);
      expect_val(tag, exp);
      push_ints     = (kind == 0);
      push_int_addr = (kind == 1);
      push_retaddr  = (kind == 2);
      #1;
      observe(d_bus);
      push_ints     = 1'b0;
      push_int_addr = 1'b0;
      push_retaddr  = 1'b0;
   endtask

   // With no push strobe the DUT must not drive, so the bench's pattern reads back intact.
   task automatic chk_float(input string tag);
      expect_val(tag, FLOAT_PAT);
      tb_drv    = FLOAT_PAT;
      tb_drv_en = 1'b1;
      #1;
      observe(d_bus);
      tb_drv_en = 1'b0;
   endtask

   task automatic ret_service(input string tag, input logic [15:0] exp);
      expect_val(tag, exp);
      push_retaddr = 1'b1;
      #1;
      observe(d_bus);
      step(1);
      push_retaddr = 1'b0;
   endtask

   task automatic wr_mask(input logic [7:0] m);
      tb_drv     = {8'h00, m};
      tb_drv_en  = 1'b1;
      write_mask = 1'b1;
      step(1);
      write_mask = 1'b0;
      tb_drv_en  = 1'b0;
   endtask

   task automatic accept(input logic [15:0] ret);
      tb_drv        = ret;
      tb_drv_en     = 1'b1;
      store_retaddr = 1'b1;
      step(1);
      store_retaddr = 1'b0;
      tb_drv_en     = 1'b0;
   endtask

   task automatic pulse_irq(input logic [7:0] v);
      irq_in = v;
      step(1);
      irq_in = 8'h00;
   endtask

   initial begin
      rst = 1'b1; irq_in = 8'h00; unmask_int = 1'b0; mask_int = 1'b0;
      write_mask = 1'b0; store_retaddr = 1'b0; push_retaddr = 1'b0;
      push_int_addr = 1'b0; push_ints = 1'b0; tb_drv = 16'h0000; tb_drv_en = 1'b0;

      // Reset then idle
      step(2);
      rst = 1'b0;
      chk_int("reset_int", 1'b0);
      chk_float("reset_bus_float");
      read_bus(0, "reset_ints", 16'h0000);

      // Basic service on channel 3
      unmask_int = 1'b1; step(1); unmask_int = 1'b0;
      wr_mask(8'hFF);
      pulse_irq(8'h08);
      chk_int("basic_int_k", 1'b0);
      step(1);
      chk_int("basic_int_k1", 1'b1);
      read_bus(0, "basic_ints", 16'h0008);
      accept(16'h1234);
      chk_int("basic_int_acc", 1'b0);
      read_bus(1, "basic_vec", 16'h001C);
      ret_service("basic_ret", 16'h1234);
      chk_int("basic_idle", 1'b0);
      step(1);
      chk_int("basic_idle2", 1'b0);

      // Priority and queuing: channels 5 and 1 together
      pulse_irq(8'h22);
      step(1);
      chk_int("prio_req", 1'b1);
      accept(16'hAAAA);
      read_bus(1, "prio_vec1", 16'h0014);
      read_bus(0, "prio_ints", 16'h0020);
      ret_service("prio_ret1", 16'hAAAA);
      chk_int("prio_r", 1'b0);
      step(1);
      chk_int("prio_r1", 1'b1);
      accept(16'h5555);
      read_bus(1, "prio_vec5", 16'h0024);
      ret_service("prio_ret5", 16'h5555);
      chk_int("prio_done", 1'b0);

      // Masking and global enable
      wr_mask(8'hF7);
      pulse_irq(8'h08);
      step(1);
      chk_int("mask_blocked", 1'b0);
      read_bus(0, "mask_pending", 16'h0008);
      wr_mask(8'hFF);
      chk_int("unmask_w", 1'b0);
      step(1);
      chk_int("unmask_w1", 1'b1);
      mask_int = 1'b1; step(1); mask_int = 1'b0;
      chk_int("gen_off_g", 1'b1);
      step(1);
      chk_int("gen_off_g1", 1'b0);
      unmask_int = 1'b1; step(1); unmask_int = 1'b0;
      chk_int("gen_on_g", 1'b0);
      step(1);
      chk_int("gen_on_g1", 1'b1);
      accept(16'h0BAD);
      ret_service("mask_ret", 16'h0BAD);

      // New edge on channel 2 in its own accept cycle
      pulse_irq(8'h04);
      step(1);
      chk_int("setclr_req", 1'b1);
      irq_in = 8'h04;
      accept(16'h4321);
      irq_in = 8'h00;
      chk_int("setclr_svc", 1'b0);
      read_bus(0, "setclr_ints", 16'h0004);
      read_bus(1, "setclr_vec", 16'h0018);

      // Reset in the middle of service
      rst = 1'b1; step(1); rst = 1'b0;
      chk_int("rst_int", 1'b0);
      chk_float("rst_bus_float");
      read_bus(0, "rst_ints", 16'h0000);
      read_bus(2, "rst_retaddr", 16'h0000);
      read_bus(1, "rst_vec", 16'h0010);

      // mask_int beats unmask_int; prior pending channel 2 must not come back
      mask_int = 1'b1; unmask_int = 1'b1; step(1); mask_int = 1'b0; unmask_int = 1'b0;
      wr_mask(8'hFF);
      pulse_irq(8'h01);
      step(2);
      chk_int("both_gen_off", 1'b0);
      read_bus(0, "both_ints", 16'h0001);
      unmask_int = 1'b1; step(1); unmask_int = 1'b0;
      chk_int("ch0_g", 1'b0);
      step(1);
      chk_int("ch0_g1", 1'b1);
      accept(16'hBEEF);
      read_bus(1, "ch0_vec", 16'h0010);
      ret_service("ch0_ret", 16'hBEEF);
      chk_int("ch0_done", 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
